// File: rtl/spram_rw_top.sv
// Single-port RAM exerciser: fills a 2^ADDR_W x DATA_W write-first RAM with mem[a]=a, then reads it back.
// Optional macro RD_CHECK_EN compiles in a sticky read-back checker; otherwise rd_check_err is tied low.
module spram_rw_top #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic [DATA_W-1:0] ram_rd_data,
   output logic              rd_check_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [ADDR_W:0]   rw_cnt;
   logic              en_r;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] douta = '0;

   // MSB of rw_cnt selects the phase: low half writes, high half reads.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         en_r   <= 1'b0;
         rw_cnt <= '0;
      end else begin
         en_r <= 1'b1;
         if (en_r) rw_cnt <= rw_cnt + 1'b1;
      end
   end

   assign ram_en      = en_r;
   assign ram_we      = en_r & ~rw_cnt[ADDR_W];
   assign ram_addr    = rw_cnt[ADDR_W-1:0];
   assign ram_wr_data = ram_we ? DATA_W'(ram_addr) : '0;

   // Write-first RAM; contents and douta survive reset.
   always_ff @(posedge sys_clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wr_data;
            douta         <= ram_wr_data;
         end else begin
            douta <= mem[ram_addr];
         end
      end
   end

   assign ram_rd_data = douta;

`ifdef RD_CHECK_EN
   logic              rd_pend;
   logic [ADDR_W-1:0] addr_d;
   logic              err_r;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         rd_pend <= 1'b0;
         addr_d  <= '0;
         err_r   <= 1'b0;
      end else begin
         rd_pend <= ram_en & ~ram_we;
         addr_d  <= ram_addr;
         if (rd_pend && (ram_rd_data != DATA_W'(addr_d))) err_r <= 1'b1;
      end
   end

   assign rd_check_err = err_r;
`else
   assign rd_check_err = 1'b0;
`endif

endmodule

// File: tb/tb_spram_rw_top.sv
// Bench for spram_rw_top: random reset bursts checked cycle-by-cycle against a behavioural model.
// With RD_CHECK_EN defined it also corrupts one RAM word and expects the sticky error flag.
module tb_spram_rw_top;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       ram_en, ram_we, rd_check_err;
   logic [4:0] ram_addr;
   logic [7:0] ram_wr_data, ram_rd_data;

   int checks = 0;
   int errors = 0;

   // Model state: enable, position in the 64-cycle period, RAM image, read port, checker.
   bit         en_m   = 1'b0;
   int         cnt_m  = 0;
   logic [7:0] mem_m [32];
   logic [7:0] dout_m = 8'h00;
   bit         pend_m = 1'b0;
   int         addrd_m = 0;
   bit         err_m  = 1'b0;

   spram_rw_top #(.ADDR_W(5), .DATA_W(8)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .ram_en       (ram_en),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wr_data  (ram_wr_data),
      .ram_rd_data  (ram_rd_data),
      .rd_check_err (rd_check_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t cnt=%0d)", tag, obs, exp, $time, cnt_m);
      end
   endtask

   // One clock edge: advance the model from pre-edge values, then compare all outputs #1 later.
   task automatic step();
      bit         e_en, e_we;
      int         e_a;
      logic [7:0] e_wd;
      @(posedge sys_clk);
      e_en = en_m;
      e_we = en_m && (cnt_m < 32);
      e_a  = cnt_m % 32;
      e_wd = e_we ? 8'(e_a) : 8'h00;
      if (sys_rst_n) begin
         if (pend_m && (dout_m != 8'(addrd_m))) err_m = 1'b1;
         pend_m  = e_en && !e_we;
         addrd_m = e_a;
         if (en_m) cnt_m = (cnt_m + 1) % 64;
         en_m = 1'b1;
      end else begin
         en_m = 1'b0; cnt_m = 0; pend_m = 1'b0; addrd_m = 0; err_m = 1'b0;
      end
      if (e_en) begin
         if (e_we) begin
            mem_m[e_a] = e_wd;
            dout_m     = e_wd;
         end else begin
            dout_m = mem_m[e_a];
         end
      end
      #1;
      e_we = en_m && (cnt_m < 32);
      check("ram_en", 32'(ram_en), 32'(en_m));
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("ram_addr", 32'(ram_addr), 32'(cnt_m % 32));
      check("ram_wr_data", 32'(ram_wr_data), e_we ? 32'(cnt_m % 32) : 32'd0);
      check("ram_rd_data", 32'(ram_rd_data), 32'(dout_m));
`ifdef RD_CHECK_EN
      check("rd_check_err", 32'(rd_check_err), 32'(err_m));
`else
      check("rd_check_err", 32'(rd_check_err), 32'd0);
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model sits at count target (bounded by one period plus margin).
   task automatic run_to(input int target);
      int k;
      k = 0;
      while (!(en_m && cnt_m == target) && k < 80) begin
         step();
         k++;
      end
      check("run_to_reached", 32'(en_m && cnt_m == target), 32'd1);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      run(10);
      sys_rst_n = 1'b1;
      run(3 * 64 + 1);

      // Directed mid-read reset at count 40.
      run_to(40);
      sys_rst_n = 1'b0;
      run(1);
      sys_rst_n = 1'b1;
      run(70);

`ifdef RD_CHECK_EN
      // Corrupt word 7 after it was written this pass but before it is read back.
      run_to(34);
      dut.mem[7] = 8'hFF;
      mem_m[7]   = 8'hFF;
      run(20);
      check("err_sticky_after_fault", 32'(rd_check_err), 32'd1);
      run(30);
      sys_rst_n = 1'b0;
      run(1);
      sys_rst_n = 1'b1;
      run(70);
`endif

      // Random reset bursts at random points in the sequence.
      for (int r = 0; r < 8; r++) begin
         run($urandom_range(150, 5));
         sys_rst_n = 1'b0;
         run($urandom_range(3, 1));
         sys_rst_n = 1'b1;
      end
      run(130);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
